alu_operand_stage: RTL

//  ID/EX pipeline register directly upstream of the 32-bit ALU. Registers decoded

---
 rtl/alu_operand_stage_pkg.sv | 24 ++
 rtl/alu_operand_stage_alu_op_decode.sv | 32 +++
 rtl/alu_operand_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - ALU operation, ALUOp and funct encodings shared with the ALU
package alu_operand_stage_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_BAD = 4'b1111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_RSVD = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_operand_stage_alu_op_decode.sv
// rtl/alu_operand_stage_alu_op_decode.sv - combinational ALUOp/funct to ALU operation decode
module alu_op_decode
  import alu_operand_stage_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] operation,
  output logic       illegal
);

  always_comb begin
    operation = OP_BAD;
    illegal   = 1'b0;
    unique case (alu_op)
      ALUOP_ADD: operation = OP_ADD;
      ALUOP_SUB: operation = OP_SUB;
      ALUOP_RTYP: begin
        unique case (funct)
          FUNCT_ADD: operation = OP_ADD;
          FUNCT_SUB: operation = OP_SUB;
          FUNCT_AND: operation = OP_AND;
          FUNCT_OR:  operation = OP_OR;
          FUNCT_SLT: operation = OP_SLT;
          FUNCT_NOR: operation = OP_NOR;
          default:   illegal   = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - ID/EX register with operand forwarding, immediate select and ALU op decode
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic          alu_src,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [DW-1:0] imm,
  input  logic          exm_wr,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_data,
  input  logic          mwb_wr,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_data,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] data_in1,
  output logic [DW-1:0] data_in2,
  output logic [3:0]    operation,
  output logic [DW-1:0] store_data,
  output logic [RW-1:0] rd_out,
  output logic          out_valid,
  output logic          illegal
);

  logic [3:0]    dec_op;
  logic          dec_illegal;
  logic [DW-1:0] rs_fwd, rt_fwd;

  logic [DW-1:0] data_in1_d, data_in1_q;
  logic [DW-1:0] data_in2_d, data_in2_q;
  logic [3:0]    operation_d, operation_q;
  logic [DW-1:0] store_data_d, store_data_q;
  logic [RW-1:0] rd_out_d, rd_out_q;
  logic          out_valid_d, out_valid_q;
  logic          illegal_d, illegal_q;

  alu_op_decode u_dec (
    .alu_op    (alu_op),
    .funct     (funct),
    .operation (dec_op),
    .illegal   (dec_illegal)
  );

  // Register 0 is hardwired, so a writeback targeting it must never be forwarded.
  always_comb begin
    rs_fwd = rs_data;
    if (rs_addr != '0) begin
      if (exm_wr && exm_rd == rs_addr)      rs_fwd = exm_data;
      else if (mwb_wr && mwb_rd == rs_addr) rs_fwd = mwb_data;
    end
    rt_fwd = rt_data;
    if (rt_addr != '0) begin
      if (exm_wr && exm_rd == rt_addr)      rt_fwd = exm_data;
      else if (mwb_wr && mwb_rd == rt_addr) rt_fwd = mwb_data;
    end
  end

  // Flush only clears the valid/illegal flags; the data registers hold.
  always_comb begin
    data_in1_d   = data_in1_q;
    data_in2_d   = data_in2_q;
    operation_d  = operation_q;
    store_data_d = store_data_q;
    rd_out_d     = rd_out_q;
    out_valid_d  = out_valid_q;
    illegal_d    = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      data_in1_d   = rs_fwd;
      data_in2_d   = alu_src ? imm : rt_fwd;
      operation_d  = dec_op;
      store_data_d = rt_fwd;
      rd_out_d     = rd_addr;
      out_valid_d  = in_valid;
      illegal_d    = in_valid & dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_in1_q   <= '0;
      data_in2_q   <= '0;
      operation_q  <= OP_ADD;
      store_data_q <= '0;
      rd_out_q     <= '0;
      out_valid_q  <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      data_in1_q   <= data_in1_d;
      data_in2_q   <= data_in2_d;
      operation_q  <= operation_d;
      store_data_q <= store_data_d;
      rd_out_q     <= rd_out_d;
      out_valid_q  <= out_valid_d;
      illegal_q    <= illegal_d;
    end
  end

  assign in_ready   = !stall;
  assign data_in1   = data_in1_q;
  assign data_in2   = data_in2_q;
  assign operation  = operation_q;
  assign store_data = store_data_q;
  assign rd_out     = rd_out_q;
  assign out_valid  = out_valid_q;
  assign illegal    = illegal_q;

endmodule
